sparse_ind_fifo: RTL and testbench
==================================

Name: sparse_ind_fifo

Overview:
- Parametrised, depth-N first-word-fall-through FIFO for sparse (value, index, row-end) triplets feeding one systolic-array row/column edge.
- Successor to the single-stage indexed FIFO: adds configurable depth, full/empty/count status, and a row-segment counter so the array starts only on complete sparse rows.
- Adds sticky overflow/underflow error flags and synchronous flush.
- One instance per array edge lane; the controller drives load and shift.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- DW_P, DW (from sys_arr_pkg), value width.
- IND_P, IND (from sys_arr_pkg), index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of contents and flags.
- load  in  1  write request.
- shift  in  1  pop-head request.
- load_vals  in  DW_P  value to write.
- load_inds  in  IND_P  column/row index of the value.
- load_ends  in  1  marks the last nonzero of a sparse row.
- out_vals  out  DW_P  head value; 0 when empty.
- out_inds  out  IND_P  head index; 0 when empty.
- out_ends  out  1  head row-end flag; 0 when empty.
- out_valid  out  1  head entry valid (equals !empty).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  $clog2(DEPTH+1)  number of stored entries.
- rows_stored  out  $clog2(DEPTH+1)  number of stored entries with ends = 1.
- row_avail  out  1  rows_stored != 0.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a shift occurred while empty.

Behaviour:
- Reset: one clock, one asynchronous active-high reset. When rst is high, pointers, count, rows_stored, overflow and underflow go to 0 immediately.
  - Outputs at reset: empty = 1; full, out_valid, row_avail and all out_* = 0.
  - Memory contents are don't-care. Reset mid-operation discards everything.
- Storage: DEPTH-entry array of fifo_entry_t, with write and read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. The count register disambiguates full from empty.
- Output timing: out_* is combinational from mem[rd_ptr], gated to 0 when empty. A write is visible on out_* the cycle after the accepting edge. No same-cycle bypass when empty.
- Priority: flush > (load, shift).
  - flush = 1: next edge clears pointers, count, rows_stored, overflow and underflow; load and shift are ignored.
- Accept rules, evaluated on the pre-edge state:
  - push_ok = load and (not full, or shift and not empty).
  - pop_ok = shift and not empty.
- Full plus load plus shift: pop and push in the same cycle; count unchanged.
- Empty plus load plus shift: push only; the shift is ignored and underflow is set.
- load while full and no shift: entry dropped, overflow set; state otherwise unchanged.
- shift while empty: no state change, underflow set.
- count: next = count + push_ok - pop_ok.
- rows_stored: +1 on push_ok with load_ends; -1 on pop_ok with head ends. Both in the same cycle leave it unchanged.
- Sticky flags hold until rst or flush.

Optional Feature:
- Macro SPARSE_IND_FIFO_ZERO_SKIP_EN.
- Defined: a load with load_vals == 0 and load_ends == 0 is discarded. It is not written, is not counted as overflow, and leaves count unchanged. A zero value with load_ends = 1 is still written so the row boundary is preserved.
- Undefined: every load is written, subject only to the full rules.

Decomposition:
- sys_arr_pkg gains:
  - typedef fifo_entry_t, a packed struct {vals [DW-1:0], inds [IND-1:0], ends}.
  - localparam FIFO_DEPTH_DEF = 8.
- Single module; pointer and count logic inline. No sub-module is needed.
- A matching interface with an IND_FIFO-style modport is updated to carry the new status ports.

Test Plan:
- Reset, then push (5,2,0), (7,4,1) -> count = 2, rows_stored = 1, row_avail = 1, out = (5,2,0). After one shift -> out = (7,4,1), rows_stored = 1.
- Fill DEPTH = 8 entries, then load (9,1,0) without shift -> full = 1, overflow = 1, count = 8, head unchanged.
- Full FIFO with load (3,3,1) and shift together -> count stays 8, head advances, and (3,3,1) emerges as the 8th pop.
- Empty FIFO with shift -> underflow = 1, out_* = 0. Then flush -> underflow = 0, empty = 1.
- Write 12 and read 12 entries interleaved -> pointers wrap and the output order matches the input order exactly.
- With SPARSE_IND_FIFO_ZERO_SKIP_EN, load (0,5,0), then (0,6,1) -> count = 1, head = (0,6,1), rows_stored = 1. Without the macro -> count = 2.

Source files
------------

// File: rtl/sys_arr_pkg.sv
// -----------------------------------------------------------------------------
// sys_arr_pkg
// Shared types and defaults for the sparse systolic-array datapath.
//   DW, IND        : default value / index widths of a sparse element
//   FIFO_DEPTH_DEF : default depth of an edge-lane sparse FIFO
//   fifo_entry_t   : one stored (value, index, row-end) triplet
//   entry_pack()   : builds a fifo_entry_t from its fields
// -----------------------------------------------------------------------------
package sys_arr_pkg;

    localparam int DW             = 16;
    localparam int IND            = 8;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef struct packed {
        logic [DW-1:0]  vals;
        logic [IND-1:0] inds;
        logic           ends;
    } fifo_entry_t;

    function automatic fifo_entry_t entry_pack(input logic [DW-1:0]  v,
                                               input logic [IND-1:0] i,
                                               input logic           e);
        fifo_entry_t t;
        t.vals = v;
        t.inds = i;
        t.ends = e;
        return t;
    endfunction

endpackage

// File: rtl/sparse_ind_fifo_if.sv
// -----------------------------------------------------------------------------
// sparse_ind_fifo_if
// Handshake + status bundle between the array controller and one edge-lane
// sparse FIFO.
//   master : controller side (drives flush/load/shift/load_*, reads status)
//   slave  : FIFO side (reverse directions)
// Signals:
//   flush, load, shift            control from controller
//   load_vals/inds/ends           triplet to write
//   out_vals/inds/ends, out_valid head entry (zeroed when empty)
//   full, empty, count            occupancy status
//   rows_stored, row_avail        complete-row bookkeeping
//   overflow, underflow           sticky error flags
// -----------------------------------------------------------------------------
interface sparse_ind_fifo_if
    import sys_arr_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int DW_P  = DW,
    parameter int IND_P = IND
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             flush;
    logic             load;
    logic             shift;
    logic [DW_P-1:0]  load_vals;
    logic [IND_P-1:0] load_inds;
    logic             load_ends;

    logic [DW_P-1:0]  out_vals;
    logic [IND_P-1:0] out_inds;
    logic             out_ends;
    logic             out_valid;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic [CW-1:0]    rows_stored;
    logic             row_avail;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, load, shift, load_vals, load_inds, load_ends,
        input  out_vals, out_inds, out_ends, out_valid, full, empty,
               count, rows_stored, row_avail, overflow, underflow
    );

    modport slave (
        input  flush, load, shift, load_vals, load_inds, load_ends,
        output out_vals, out_inds, out_ends, out_valid, full, empty,
               count, rows_stored, row_avail, overflow, underflow
    );

endinterface

// File: rtl/sparse_ind_fifo.sv
// -----------------------------------------------------------------------------
// sparse_ind_fifo
// Depth-N first-word-fall-through FIFO of sparse (value, index, row-end)
// triplets for one systolic-array edge lane. Tracks how many complete sparse
// rows are stored so the array can be started only on whole rows.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : sparse_ind_fifo_if.slave (control, load data, head, status)
// Optional build macro:
//   SPARSE_IND_FIFO_ZERO_SKIP_EN : drop loads whose value is zero and that do
//   not close a row (not stored, not counted as overflow).
// -----------------------------------------------------------------------------
module sparse_ind_fifo
    import sys_arr_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int DW_P  = DW,
    parameter int IND_P = IND
)(
    input  logic              clk,
    input  logic              rst,
    sparse_ind_fifo_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DW_P-1:0]  vals;
        logic [IND_P-1:0] inds;
        logic             ends;
    } entry_t;

    // Storage (contents are not reset)
    entry_t           r_mem [DEPTH];

    logic [PW-1:0]    r_wr_ptr, w_wr_ptr_next;
    logic [PW-1:0]    r_rd_ptr, w_rd_ptr_next;
    logic [CW-1:0]    r_count,  w_count_next;
    logic [CW-1:0]    r_rows,   w_rows_next;
    logic             r_ovf,    w_ovf_next;
    logic             r_udf,    w_udf_next;

    logic             w_empty;
    logic             w_full;
    logic             w_load_req;
    logic             w_push_ok;
    logic             w_pop_ok;
    entry_t           w_head;
    entry_t           w_wr_entry;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_head  = r_mem[r_rd_ptr];

    assign w_wr_entry.vals = bus.load_vals;
    assign w_wr_entry.inds = bus.load_inds;
    assign w_wr_entry.ends = bus.load_ends;

`ifdef SPARSE_IND_FIFO_ZERO_SKIP_EN
    // A zero that closes a row is still stored so the row boundary survives.
    assign w_load_req = bus.load & ~((bus.load_vals == '0) & ~bus.load_ends);
`else
    assign w_load_req = bus.load;
`endif

    // A full FIFO can still accept when the head leaves in the same cycle.
    assign w_pop_ok  = bus.shift & ~w_empty;
    assign w_push_ok = w_load_req & (~w_full | w_pop_ok);

    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_count_next  = r_count;
        w_rows_next   = r_rows;
        w_ovf_next    = r_ovf;
        w_udf_next    = r_udf;

        if (bus.flush) begin
            w_wr_ptr_next = '0;
            w_rd_ptr_next = '0;
            w_count_next  = '0;
            w_rows_next   = '0;
            w_ovf_next    = 1'b0;
            w_udf_next    = 1'b0;
        end else begin
            if (w_push_ok) begin
                w_wr_ptr_next = r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                w_rd_ptr_next = r_rd_ptr + PW'(1);
            end
            w_count_next = r_count + CW'(w_push_ok) - CW'(w_pop_ok);
            w_rows_next  = r_rows + CW'(w_push_ok & bus.load_ends)
                                  - CW'(w_pop_ok & w_head.ends);
            if (w_load_req & ~w_push_ok) begin
                w_ovf_next = 1'b1;
            end
            if (bus.shift & w_empty) begin
                w_udf_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rows   <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            r_rows   <= w_rows_next;
            r_ovf    <= w_ovf_next;
            r_udf    <= w_udf_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok & ~bus.flush) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // Head is read straight from the array; a write becomes visible only
    // after the accepting edge, there is no bypass into an empty FIFO.
    assign bus.out_vals    = w_empty ? '0 : w_head.vals;
    assign bus.out_inds    = w_empty ? '0 : w_head.inds;
    assign bus.out_ends    = w_empty ? 1'b0 : w_head.ends;
    assign bus.out_valid   = ~w_empty;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.count       = r_count;
    assign bus.rows_stored = r_rows;
    assign bus.row_avail   = (r_rows != '0);
    assign bus.overflow    = r_ovf;
    assign bus.underflow   = r_udf;

endmodule

// File: tb/tb_sparse_ind_fifo.sv
module tb_sparse_ind_fifo;
    import sys_arr_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    sparse_ind_fifo_if #(.DEPTH(DEPTH), .DW_P(DW), .IND_P(IND)) bus_if ();

    sparse_ind_fifo #(.DEPTH(DEPTH), .DW_P(DW), .IND_P(IND)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    function automatic logic [31:0] ent(input int v, input int i, input bit e);
        logic [31:0] r;
        r = {7'b0, v[15:0], i[7:0], e};
        return r;
    endfunction

    function automatic logic [31:0] head();
        logic [31:0] r;
        r = {7'b0, bus_if.out_vals, bus_if.out_inds, bus_if.out_ends};
        return r;
    endfunction

    // Drive one cycle of control at the falling edge, return 1 time unit
    // after the following rising edge with inputs back to idle.
    task automatic step(input bit ld, input int v, input int i, input bit e,
                        input bit sh, input bit fl);
        @(negedge clk);
        bus_if.load      = ld;
        bus_if.load_vals = v[15:0];
        bus_if.load_inds = i[7:0];
        bus_if.load_ends = e;
        bus_if.shift     = sh;
        bus_if.flush     = fl;
        @(posedge clk);
        #1;
        bus_if.load  = 1'b0;
        bus_if.shift = 1'b0;
        bus_if.flush = 1'b0;
    endtask

    initial begin
        bus_if.load      = 1'b0;
        bus_if.shift     = 1'b0;
        bus_if.flush     = 1'b0;
        bus_if.load_vals = '0;
        bus_if.load_inds = '0;
        bus_if.load_ends = 1'b0;

        // Reset state
        #2;
        check("rst_empty",     32'(bus_if.empty), 32'd1);
        check("rst_full",      32'(bus_if.full), 32'd0);
        check("rst_valid",     32'(bus_if.out_valid), 32'd0);
        check("rst_row_avail", 32'(bus_if.row_avail), 32'd0);
        check("rst_count",     32'(bus_if.count), 32'd0);
        check("rst_head",      head(), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Two pushes, one completing a row
        step(1, 5, 2, 0, 0, 0);
        step(1, 7, 4, 1, 0, 0);
        check("p2_count", 32'(bus_if.count), 32'd2);
        check("p2_rows",  32'(bus_if.rows_stored), 32'd1);
        check("p2_avail", 32'(bus_if.row_avail), 32'd1);
        check("p2_head",  head(), ent(5, 2, 0));
        step(0, 0, 0, 0, 1, 0);
        check("s1_head",  head(), ent(7, 4, 1));
        check("s1_rows",  32'(bus_if.rows_stored), 32'd1);
        step(0, 0, 0, 0, 1, 0);
        check("s2_empty", 32'(bus_if.empty), 32'd1);
        check("s2_rows",  32'(bus_if.rows_stored), 32'd0);

        // Fill, then overflow
        for (int k = 0; k < DEPTH; k++) step(1, 10 + k, k, 0, 0, 0);
        check("fill_full",  32'(bus_if.full), 32'd1);
        step(1, 9, 1, 0, 0, 0);
        check("ovf_flag",   32'(bus_if.overflow), 32'd1);
        check("ovf_count",  32'(bus_if.count), 32'd8);
        check("ovf_full",   32'(bus_if.full), 32'd1);
        check("ovf_head",   head(), ent(10, 0, 0));

        // Full with simultaneous load and shift
        step(1, 3, 3, 1, 1, 0);
        check("fls_count", 32'(bus_if.count), 32'd8);
        check("fls_rows",  32'(bus_if.rows_stored), 32'd1);
        for (int k = 1; k < DEPTH; k++) begin
            check($sformatf("drain_head%0d", k), head(), ent(10 + k, k, 0));
            step(0, 0, 0, 0, 1, 0);
        end
        check("drain_head8", head(), ent(3, 3, 1));
        step(0, 0, 0, 0, 1, 0);
        check("drain_empty", 32'(bus_if.empty), 32'd1);
        check("drain_rows",  32'(bus_if.rows_stored), 32'd0);

        // Underflow then flush
        step(0, 0, 0, 0, 1, 0);
        check("udf_flag",  32'(bus_if.underflow), 32'd1);
        check("udf_head",  head(), 32'd0);
        check("udf_count", 32'(bus_if.count), 32'd0);
        step(1, 1, 1, 1, 0, 1);
        check("flush_udf",   32'(bus_if.underflow), 32'd0);
        check("flush_ovf",   32'(bus_if.overflow), 32'd0);
        check("flush_empty", 32'(bus_if.empty), 32'd1);

        // Empty with load and shift: push only, underflow set
        step(1, 42, 9, 0, 1, 0);
        check("els_count", 32'(bus_if.count), 32'd1);
        check("els_udf",   32'(bus_if.underflow), 32'd1);
        check("els_head",  head(), ent(42, 9, 0));
        step(0, 0, 0, 0, 0, 1);

        // Interleaved 12-in / 12-out across pointer wrap
        step(1, 100, 0, 0, 0, 0);
        for (int k = 1; k < 12; k++) begin
            check($sformatf("wrap_head%0d", k - 1), head(), ent(100 + k - 1, k - 1, ((k - 1) % 3) == 2));
            step(1, 100 + k, k, (k % 3) == 2, 1, 0);
        end
        check("wrap_count",  32'(bus_if.count), 32'd1);
        check("wrap_head11", head(), ent(111, 11, 1));
        check("wrap_rows",   32'(bus_if.rows_stored), 32'd1);
        step(0, 0, 0, 0, 1, 0);
        check("wrap_empty",  32'(bus_if.empty), 32'd1);

        // Zero-valued entries
        step(1, 0, 5, 0, 0, 0);
        step(1, 0, 6, 1, 0, 0);
`ifdef SPARSE_IND_FIFO_ZERO_SKIP_EN
        check("zs_count", 32'(bus_if.count), 32'd1);
        check("zs_head",  head(), ent(0, 6, 1));
`else
        check("zs_count", 32'(bus_if.count), 32'd2);
        check("zs_head",  head(), ent(0, 5, 0));
`endif
        check("zs_rows",  32'(bus_if.rows_stored), 32'd1);
        check("zs_ovf",   32'(bus_if.overflow), 32'd0);

        // Asynchronous reset mid-operation
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_count", 32'(bus_if.count), 32'd0);
        check("arst_empty", 32'(bus_if.empty), 32'd1);
        check("arst_avail", 32'(bus_if.row_avail), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
